pll_drp_ctrl: RTL and testbench



---
 rtl/pll_drp_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl: PLLE2_ADV DRP sequencer that rewrites the CLKOUT0 divide.
// Define PLL_DRP_TIMEOUT_EN to add the DRDY/LOCKED watchdog.
module pll_drp_ctrl #(
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [6:0]  div_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic        pll_rst_o,
  input  logic        pll_locked_i,
  output logic [6:0]  daddr_o,
  output logic        den_o,
  output logic        dwe_o,
  output logic [15:0] di_o,
  input  logic [15:0] do_i,
  input  logic        drdy_i,
  output logic        clk_stable_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_LOCK_WAIT
  } state_e;

  localparam logic [6:0] ADDR_REG1 = 7'h08;
  localparam logic [6:0] ADDR_REG2 = 7'h09;
  localparam logic [7:0] CNT_LAST  = 8'(RST_CYCLES - 1);

  if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst
    $error("RST_CYCLES must be 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  div_q, div_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] rd_q, rd_d;
  logic        lock_s1_q, lock_s2_q;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        prst_q, prst_d;
  logic        den_q, den_d;
  logic        dwe_q, dwe_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [15:0] di_q, di_d;
  logic [5:0]  hi6, lo6;
  logic [15:0] wr_val;

`ifdef PLL_DRP_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
`endif

  // low = D - D>>1 = ceil(D/2); cannot overflow for D <= 126
  assign hi6 = div_q[6:1];
  assign lo6 = div_q[6:1] + 6'(div_q[0]);

  always_comb begin
    if (addr_q == ADDR_REG1) begin
      wr_val = (rd_d & 16'hF000) | {4'b0, hi6, lo6};
    end else begin
      wr_val = (rd_d & 16'hFF3F)
             | {8'b0, div_q[0], (div_q == 7'd1), 6'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (div_i == 7'd0 || div_i > 7'd126) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            div_d   = div_i;
            addr_d  = ADDR_REG1;
            cnt_d   = '0;
            state_d = S_RST_HOLD;
          end
        end
      end
      S_RST_HOLD: begin
        if (cnt_q == CNT_LAST) state_d = S_RD;
        else cnt_d = cnt_q + 8'd1;
      end
      S_RD: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (drdy_i) begin
          rd_d    = do_i;
          state_d = S_WR;
        end
      end
      S_WR: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (drdy_i) begin
          if (addr_q == ADDR_REG1) begin
            addr_d  = ADDR_REG2;
            state_d = S_RD;
          end else begin
            state_d = S_LOCK_WAIT;
          end
        end
      end
      S_LOCK_WAIT: begin
        if (lock_s2_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PLL_DRP_TIMEOUT_EN
    wdog_d = '0;
    if (state_d == state_q &&
        state_q inside {S_RD_WAIT, S_WR_WAIT, S_LOCK_WAIT}) begin
      if (wdog_q == WDOG_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        done_d  = 1'b1;
      end else begin
        wdog_d = wdog_q + 16'd1;
      end
    end
`endif

    // Outputs are registered from the next state so they align with it
    ready_d = (state_d == S_IDLE);
    prst_d  = state_d inside {S_RST_HOLD, S_RD, S_RD_WAIT,
                              S_WR, S_WR_WAIT};
    den_d   = (state_d == S_RD) || (state_d == S_WR);
    dwe_d   = (state_d == S_WR);
    daddr_d = den_d ? addr_d : 7'd0;
    di_d    = dwe_d ? wr_val : 16'd0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      addr_q    <= '0;
      rd_q      <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      prst_q    <= 1'b0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
`ifdef PLL_DRP_TIMEOUT_EN
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      lock_s1_q <= pll_locked_i;
      lock_s2_q <= lock_s1_q;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      prst_q    <= prst_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
`ifdef PLL_DRP_TIMEOUT_EN
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign ready_o      = ready_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign pll_rst_o    = prst_q;
  assign den_o        = den_q;
  assign dwe_o        = dwe_q;
  assign daddr_o      = daddr_q;
  assign di_o         = di_q;
  assign clk_stable_o = ready_q & lock_s2_q;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// tb_pll_drp_ctrl: directed bench with DRP memory and PLL lock models.
// Define PLL_DRP_TIMEOUT_EN to also exercise the watchdog.
module tb_pll_drp_ctrl;

  localparam int RST_CYC  = 4;
  localparam int TO_CYC   = 1024;
  localparam int LOCK_DLY = 3;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic [6:0]  div_i;
  logic        ready_o, done_o, err_o, pll_rst_o;
  logic        pll_locked_i;
  logic [6:0]  daddr_o;
  logic        den_o, dwe_o;
  logic [15:0] di_o, do_i;
  logic        drdy_i;
  logic        clk_stable_o;

  pll_drp_ctrl #(
    .RST_CYCLES    (RST_CYC),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .div_i       (div_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .pll_rst_o   (pll_rst_o),
    .pll_locked_i(pll_locked_i),
    .daddr_o     (daddr_o),
    .den_o       (den_o),
    .dwe_o       (dwe_o),
    .di_o        (di_o),
    .do_i        (do_i),
    .drdy_i      (drdy_i),
    .clk_stable_o(clk_stable_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] data;
  } acc_t;

  acc_t        exp_q[$];
  logic [22:0] wr_log[$];

  // DRP register file and handshake model
  logic [15:0] mem [0:127];
  bit          pending, pend_we, hold_wr, hold_rd, spur;
  logic [6:0]  pend_addr;
  logic [15:0] pend_di;
  int          wait_cnt, lat;

  always @(negedge clk) begin
    drdy_i = 1'b0;
    do_i   = 16'hBAD0;
    if (!rst_ni) pending = 1'b0;
    if (pending) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else if (!(hold_wr && pend_we) && !(hold_rd && !pend_we)) begin
        drdy_i  = 1'b1;
        pending = 1'b0;
        if (pend_we) mem[pend_addr] = pend_di;
        else do_i = mem[pend_addr];
      end
    end else if (spur && $urandom_range(0, 2) == 0) begin
      drdy_i = 1'b1;
      do_i   = 16'hFFFF;
    end
    if (den_o) begin
      pending   = 1'b1;
      pend_we   = dwe_o;
      pend_addr = daddr_o;
      pend_di   = di_o;
      wait_cnt  = lat - 1;
    end
  end

  // PLL: unlocked while in reset, locks LOCK_DLY cycles after release
  int lk_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (pll_rst_o === 1'b1) begin
      lk_cnt       = 0;
      pll_locked_i = 1'b0;
    end else begin
      if (lk_cnt < LOCK_DLY) lk_cnt++;
      pll_locked_i = (lk_cnt >= LOCK_DLY);
    end
  end

  // Per-cycle compare against the access scoreboard and output rules
  bit   prev_den, exp_err, lk1, lk2;
  int   rst_run, done_cnt, den_cnt, rst_cyc, since_rst;
  acc_t e;

  always @(negedge clk) begin
    if (den_o) begin
      chk("den_single", 32'(prev_den), 0);
      chk("den_in_rst", 32'(pll_rst_o), 1);
      if (exp_q.size() == 0) begin
        chk("den_unexpected", 32'(den_o), 0);
      end else begin
        e = exp_q.pop_front();
        chk("drp_addr", 32'(daddr_o), 32'(e.addr));
        chk("drp_we", 32'(dwe_o), 32'(e.we));
        if (e.we) chk("drp_di", 32'(di_o), 32'(e.data));
      end
      if (dwe_o) wr_log.push_back({daddr_o, di_o});
      if (!dwe_o && daddr_o == 7'h08)
        chk("rst_hold_len", 32'(rst_run >= RST_CYC), 1);
      den_cnt++;
    end else begin
      chk("bus_idle", 32'({dwe_o, daddr_o, di_o}), 0);
    end
    if (ready_o) chk("ready_no_rst", 32'(pll_rst_o), 0);
    if (done_o) begin
      chk("done_in_idle", 32'(ready_o), 1);
      done_cnt++;
    end else begin
      chk("err_flag", 32'(err_o), 32'(exp_err));
    end
    if (since_rst >= 3)
      chk("clk_stable", 32'(clk_stable_o), 32'(ready_o & lk2));
    if (pll_rst_o) rst_cyc++;
    rst_run   = pll_rst_o ? rst_run + 1 : 0;
    prev_den  = den_o;
    lk2       = lk1;
    lk1       = pll_locked_i;
    since_rst = rst_ni ? since_rst + 1 : 0;
  end

  task automatic expect_op(input int d);
    int          hi, lo, eg, nc;
    logic [15:0] v8, v9;
    hi = d / 2;
    lo = d - hi;
    eg = d % 2;
    nc = (d == 1) ? 1 : 0;
    v8 = 16'((mem[8] & 16'hF000) + hi * 64 + lo);
    v9 = 16'((mem[9] & 16'hFF3F) + nc * 64 + eg * 128);
    exp_q.push_back('{7'h08, 1'b0, 16'h0});
    exp_q.push_back('{7'h08, 1'b1, v8});
    exp_q.push_back('{7'h09, 1'b0, 16'h0});
    exp_q.push_back('{7'h09, 1'b1, v9});
  endtask

  task automatic do_op(input logic [6:0] d, input bit hold,
                       input bit exp_e, input int exp_den,
                       output int k);
    int den0, rst0, done0;
    bit valid;
    valid = (d != 7'd0) && (d <= 7'd126);
    @(negedge clk);
    chk("ready_pre", 32'(ready_o), 1);
    if (valid) expect_op(int'(d));
    wr_log.delete();
    den0  = den_cnt;
    rst0  = rst_cyc;
    done0 = done_cnt;
    req_i = 1'b1;
    div_i = d;
    @(posedge clk);
    #1;
    if (!hold) req_i = 1'b0;
    div_i = 7'd50;
    if (valid) exp_err = 1'b0;
    k = 0;
    @(negedge clk);
    while (!done_o && k < 4000) begin
      @(negedge clk);
      k++;
    end
    req_i = 1'b0;
    chk("done_seen", 32'(done_o), 1);
    chk("err_end", 32'(err_o), 32'(exp_e));
    chk("rst_end", 32'(pll_rst_o), 0);
    exp_err = exp_e;
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt - done0), 1);
    chk("den_count", 32'(den_cnt - den0), 32'(exp_den));
    if (!valid) chk("rst_none", 32'(rst_cyc - rst0), 0);
    if (exp_den == 4) chk("q_empty", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  int k;

  initial begin
    rst_ni       = 1'b0;
    req_i        = 1'b0;
    div_i        = 7'd0;
    drdy_i       = 1'b0;
    do_i         = 16'h0;
    pll_locked_i = 1'b0;
    lat          = 1;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    mem[8] = 16'h1041;
    mem[9] = 16'h0080;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_pll", 32'(pll_rst_o), 0);
    chk("rst_bus", 32'({den_o, dwe_o, daddr_o, di_o}), 0);
    chk("rst_stable", 32'(clk_stable_o), 0);
    rst_ni = 1'b1;
    repeat (8) @(negedge clk);
    chk("stable_idle", 32'(clk_stable_o), 1);

    // divide 24 against 16'h1041 / 16'h0080
    do_op(7'd24, 1'b0, 1'b0, 4, k);
    chk("lat_div24", 32'(k), 17);
    chk("wr0_div24", 32'(wr_log[0]), {9'h0, 7'h08, 16'h130C});
    chk("wr1_div24", 32'(wr_log[1]), {9'h0, 7'h09, 16'h0000});

    // divide 1, slow DRP, stray DRDY pulses
    mem[8] = 16'hFFFF;
    mem[9] = 16'h1234;
    lat    = 3;
    spur   = 1'b1;
    do_op(7'd1, 1'b0, 1'b0, 4, k);
    chk("wr0_div1", 32'(wr_log[0]), {9'h0, 7'h08, 16'hF001});
    chk("wr1_div1", 32'(wr_log[1]), {9'h0, 7'h09, 16'h12F4});
    spur = 1'b0;
    lat  = 1;

    do_op(7'd0, 1'b0, 1'b1, 0, k);
    chk("lat_div0", 32'(k), 0);
    do_op(7'd127, 1'b0, 1'b1, 0, k);
    chk("lat_div127", 32'(k), 0);

    // request held through the operation; clears the sticky error
    do_op(7'd24, 1'b1, 1'b0, 4, k);
    chk("lat_held", 32'(k), 17);
    do_op(7'd126, 1'b0, 1'b0, 4, k);

    // reset while waiting for the first write to complete
    expect_op(20);
    hold_wr = 1'b1;
    @(negedge clk);
    req_i = 1'b1;
    div_i = 7'd20;
    @(posedge clk);
    #1;
    req_i   = 1'b0;
    exp_err = 1'b0;
    k = 0;
    @(negedge clk);
    while (!(den_o && dwe_o) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wr_reached", 32'(den_o & dwe_o), 1);
    @(negedge clk);
    chk("wr_wait_rst", 32'(pll_rst_o), 1);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mid_rst_pll", 32'(pll_rst_o), 0);
    chk("mid_rst_den", 32'(den_o), 0);
    chk("mid_rst_ready", 32'(ready_o), 1);
    chk("mid_rst_done", 32'(done_o), 0);
    exp_q.delete();
    hold_wr = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (8) @(negedge clk);
    chk("relock_stable", 32'(clk_stable_o), 1);
    do_op(7'd7, 1'b0, 1'b0, 4, k);
    chk("lat_after_rst", 32'(k), 17);

`ifdef PLL_DRP_TIMEOUT_EN
    hold_rd = 1'b1;
    do_op(7'd30, 1'b0, 1'b1, 1, k);
    chk("timeout_lat", 32'(k), 32'(RST_CYC + 1 + TO_CYC));
    hold_rd = 1'b0;
    repeat (4) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
